seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 189 ++++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed seven-segment scanner.
// Each digit slot is BLANK_CYCLES dark cycles followed by a lit SHOW phase,
// REFRESH_DIV cycles in total. Four slots form a frame. The displayed data
// comes from a shadow register that changes only at a frame start, so the
// digits in one frame always belong to the same captured value.
//
// Load interface: load is a one-cycle strobe with no ready/backpressure.
// The block accepts value/dp/lz_en on every cycle where load = 1. A newer
// load overwrites an older one that has not yet reached the shadow.
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp,
  input  logic        lz_en,
  output logic [3:0]  digit_bin,
  input  logic [6:0]  seg_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame,
  output logic        state_dbg
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          en_q;

  logic [15:0]   pend_value;
  logic [3:0]    pend_dp;
  logic          pend_lz;
  logic          pend_valid;

  logic [15:0]   sh_value;
  logic [3:0]    sh_dp;
  logic          sh_lz;

  logic          slot_end;
  logic          frame_start;
  logic [3:0]    suppress;

  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dpn_d;

  assign state_dbg = (state_q == ST_SHOW);
  assign slot_end  = (cnt_q == SLOT_LAST);

  // A frame starts when the last slot of digit 3 ends, or on the first
  // enabled cycle after enable was low (that cycle holds the scan at start).
  assign frame_start = enable &
                       (~en_q | ((state_q == ST_SHOW) & slot_end & (idx_q == 2'd3)));

  // Leading-zero suppression: digit i is dark when it and every digit to
  // its left are zero. Digit 0 always shows so a zero value reads "0".
  assign suppress[0] = 1'b0;
  assign suppress[1] = sh_lz & (sh_value[15:4]  == 12'h000);
  assign suppress[2] = sh_lz & (sh_value[15:8]  == 8'h00);
  assign suppress[3] = sh_lz & (sh_value[15:12] == 4'h0);

  // Nibble of the digit currently being scanned, for the external decoder.
  always_comb begin
    digit_bin = sh_value[3:0];
    case (idx_q)
      2'd0:    digit_bin = sh_value[3:0];
      2'd1:    digit_bin = sh_value[7:4];
      2'd2:    digit_bin = sh_value[11:8];
      default: digit_bin = sh_value[15:12];
    endcase
  end

  // Scan state register (state, slot counter, digit index, enable history).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      en_q    <= enable;
    end
  end

  // Next-state logic: held at BLANK/0/0 while disabled and on the restart cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    if (!enable || !en_q) begin
      state_d = ST_BLANK;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
        end
        default: begin
          if (slot_end) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Output decode from the current scan state; only one anode can be low.
  always_comb begin
    an_d  = 4'hF;
    seg_d = 7'h7F;
    dpn_d = 1'b1;
    if (enable && (state_q == ST_SHOW)) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = suppress[idx_q] ? 7'h7F : ~seg_in;
      dpn_d = ~sh_dp[idx_q];
    end
  end

  // Registered pin drivers and frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      an    <= 4'hF;
      seg   <= 7'h7F;
      dp_n  <= 1'b1;
      frame <= 1'b0;
    end else begin
      an    <= an_d;
      seg   <= seg_d;
      dp_n  <= dpn_d;
      frame <= frame_start;
    end
  end

  // Pending/shadow data path: loads land in pending, which moves to the
  // shadow only at a frame start; a load on the frame-start cycle bypasses.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_value <= 16'h0000;
      pend_dp    <= 4'h0;
      pend_lz    <= 1'b0;
      pend_valid <= 1'b0;
      sh_value   <= 16'h0000;
      sh_dp      <= 4'h0;
      sh_lz      <= 1'b0;
    end else if (load && frame_start) begin
      sh_value   <= value;
      sh_dp      <= dp;
      sh_lz      <= lz_en;
      pend_valid <= 1'b0;
    end else begin
      if (frame_start && pend_valid) begin
        sh_value   <= pend_value;
        sh_dp      <= pend_dp;
        sh_lz      <= pend_lz;
        pend_valid <= 1'b0;
      end
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp;
        pend_lz    <= lz_en;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=8, BLANK_CYCLES=2
// (32-cycle frame) and a hex-to-segment decoder model on digit_bin/seg_in.
module tb_seven_seg_scanner;

  localparam int RD = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz_en;
  logic [3:0]  digit_bin;
  logic [6:0]  seg_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n;
  logic        frame;
  logic        state_dbg;

  int checks = 0;
  int errors = 0;

  // Expected shadow value for each upcoming checked frame.
  logic [15:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- decoder model (segments gfedcba, 1 = lit) ----------------
  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign seg_in = hex7(digit_bin);

  seven_seg_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .load      (load),
    .value     (value),
    .dp        (dp),
    .lz_en     (lz_en),
    .digit_bin (digit_bin),
    .seg_in    (seg_in),
    .an        (an),
    .seg       (seg),
    .dp_n      (dp_n),
    .frame     (frame),
    .state_dbg (state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input logic [15:0] v, input logic [3:0] d, input logic lz);
    load  = 1'b1;
    value = v;
    dp    = d;
    lz_en = lz;
  endtask

  // Walks one frame starting at the sample where frame = 1 (sample 0) and
  // ends on the sample that shows the next frame pulse. Loads are driven at
  // sample ld_k0 / ld_k1 (captured on the following edge; -1 = none).
  task automatic run_frame(input string name, input logic [27:0] exp_seg,
                           input logic [3:0] exp_dpn,
                           input int ld_k0, input logic [15:0] ld_v0,
                           input int ld_k1, input logic [15:0] ld_v1,
                           input logic [3:0] ld_dp, input logic ld_lz);
    logic [15:0] exp_bin;
    logic [3:0]  exp_an;
    logic        exp_frame;
    int s, p;
    exp_bin = 16'h0000;
    if (exp_q.size() > 0) exp_bin = exp_q.pop_front();
    for (int k = 1; k <= 32; k++) begin
      if (k - 1 == ld_k0) drive_load(ld_v0, ld_dp, ld_lz);
      else if (k - 1 == ld_k1) drive_load(ld_v1, ld_dp, ld_lz);
      step();
      load = 1'b0;
      s = (k - 1) / 8;
      p = (k - 1) % 8;
      exp_frame = (k == 32) ? 1'b1 : 1'b0;
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL %s one_anode k=%0d: an=%h has more than one low bit", name, k, an);
      end
      checks++;
      if (frame !== exp_frame) begin
        errors++;
        $display("FAIL %s frame k=%0d: got %b expected %b", name, k, frame, exp_frame);
      end
      if (p < 2) begin
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1) begin
          errors++;
          $display("FAIL %s blank k=%0d: an=%h seg=%h dp_n=%b expected F/7f/1",
                   name, k, an, seg, dp_n);
        end
      end else begin
        exp_an = 4'hF ^ (4'b0001 << s);
        checks++;
        if (an !== exp_an) begin
          errors++;
          $display("FAIL %s an k=%0d: got %h expected %h", name, k, an, exp_an);
        end
        checks++;
        if (seg !== exp_seg[7*s +: 7]) begin
          errors++;
          $display("FAIL %s seg digit%0d k=%0d: got %h expected %h",
                   name, s, k, seg, exp_seg[7*s +: 7]);
        end
        checks++;
        if (dp_n !== exp_dpn[s]) begin
          errors++;
          $display("FAIL %s dp_n digit%0d k=%0d: got %b expected %b",
                   name, s, k, dp_n, exp_dpn[s]);
        end
      end
      if (p == 3) begin
        checks++;
        if (digit_bin !== exp_bin[4*s +: 4]) begin
          errors++;
          $display("FAIL %s digit_bin digit%0d: got %h expected %h",
                   name, s, digit_bin, exp_bin[4*s +: 4]);
        end
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b1;
    drive_load(16'hFFFF, 4'hF, 1'b1);
    step();
    step();
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || frame !== 1'b0) begin
      errors++;
      $display("FAIL reset outputs: an=%h seg=%h dp_n=%b frame=%b expected F/7f/1/0",
               an, seg, dp_n, frame);
    end
    checks++;
    if (digit_bin !== 4'h0 || state_dbg !== 1'b0) begin
      errors++;
      $display("FAIL reset state: digit_bin=%h state=%b expected 0/0", digit_bin, state_dbg);
    end
    load = 1'b0; value = 16'h0000; dp = 4'h0; lz_en = 1'b0;
  endtask

  task automatic test_start();
    reset = 1'b0;
    step();
    checks++;
    if (frame !== 1'b1) begin
      errors++;
      $display("FAIL start frame: got %b expected 1", frame);
    end
  endtask

  task automatic test_enable_drop();
    for (int k = 1; k <= 20; k++) step();
    checks++;
    if (an !== 4'hB) begin
      errors++;
      $display("FAIL drop pre an: got %h expected b", an);
    end
    enable = 1'b0;
    drive_load(16'h4321, 4'h0, 1'b0);
    step();
    load = 1'b0;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || frame !== 1'b0) begin
      errors++;
      $display("FAIL drop dark: an=%h seg=%h dp_n=%b frame=%b expected F/7f/1/0",
               an, seg, dp_n, frame);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (an !== 4'hF || frame !== 1'b0) begin
        errors++;
        $display("FAIL drop hold %0d: an=%h frame=%b expected F/0", k, an, frame);
      end
    end
    enable = 1'b1;
    step();
    checks++;
    if (frame !== 1'b1) begin
      errors++;
      $display("FAIL reenable frame: got %b expected 1", frame);
    end
    exp_q.push_back(16'h4321);
    run_frame("reenable_4321", {7'h19, 7'h30, 7'h24, 7'h79}, 4'hF, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 5; k++) step();
    drive_load(16'h8888, 4'hF, 1'b0);
    step();
    load = 1'b0;
    for (int k = 7; k <= 12; k++) step();
    checks++;
    if (an !== 4'hD) begin
      errors++;
      $display("FAIL midreset pre an: got %h expected d", an);
    end
    reset = 1'b1;
    step();
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dp_n !== 1'b1 || frame !== 1'b0) begin
      errors++;
      $display("FAIL midreset dark: an=%h seg=%h dp_n=%b frame=%b expected F/7f/1/0",
               an, seg, dp_n, frame);
    end
    reset = 1'b0;
    step();
    checks++;
    if (frame !== 1'b1) begin
      errors++;
      $display("FAIL midreset restart frame: got %b expected 1", frame);
    end
    exp_q.push_back(16'h0000);
    run_frame("after_reset_zero", {4{7'h40}}, 4'hF, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0;
    value = 16'h0000; dp = 4'h0; lz_en = 1'b0;
    test_reset();
    test_start();
    // Zeros while 1234 is loaded mid-frame (slot 1).
    exp_q.push_back(16'h0000);
    run_frame("zero_midload", {4{7'h40}}, 4'hF, 10, 16'h1234, -1, 16'h0, 4'h0, 1'b0);
    // 1234 shown; load 0070 with suppression and dp on digit 3.
    exp_q.push_back(16'h1234);
    run_frame("show_1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 20, 16'h0070, -1, 16'h0, 4'b1000, 1'b1);
    // 0070 suppressed; two loads, only the later should land.
    exp_q.push_back(16'h0070);
    run_frame("lz_0070", {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0111, 5, 16'hAAAA, 12, 16'h5555, 4'h0, 1'b0);
    // 5555 shown; load on the frame-start cycle.
    exp_q.push_back(16'h5555);
    run_frame("last_load_5555", {4{7'h12}}, 4'hF, 31, 16'h9876, -1, 16'h0, 4'h0, 1'b0);
    // Coincident load visible immediately.
    exp_q.push_back(16'h9876);
    run_frame("coincident_9876", {7'h10, 7'h00, 7'h78, 7'h02}, 4'hF, -1, 16'h0, -1, 16'h0, 4'h0, 1'b0);
    test_enable_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
